sysid_check_master: RTL and testbench

- Avalon-MM master that reads the system-ID control slave and checks its contents against build-time values.
- Reads address 0 (system ID), then address 1 (build timestamp).
- Compares both words with parameters and reports done/pass/mismatch/timeout to the Nios-less boot sequencer and the board status LEDs.
- Sits on the same interconnect as the ID slave; the interconnect may insert wait states and read latency.

---
 rtl/sysid_pkg.sv | 23 ++
 rtl/sysid_rd_timer.sv | 34 +++
 rtl/sysid_check_master.sv | 156 +++++++++++++++
 tb/tb_sysid_check_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker and the ID slave generator.
package sysid_pkg;

  localparam int unsigned SYSID_DATA_W = 32;

  // Word addresses inside the system-ID control slave.
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Build-time defaults, shared with the ID slave generator.
  localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_ID        = 32'd0;
  localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_TIMESTAMP = 32'd1739663930;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    DONE
  } sysid_state_e;

endpackage

// File: rtl/sysid_rd_timer.sv
// Per-transaction read timer: loadable up-counter with terminal-count flag.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : clear the count to zero (wins over en)
//   en             : count one cycle
//   tc_c           : count has reached the last allowed cycle (combinational)
module sysid_rd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] count;

  // Count holds (cycles elapsed - 1), so tc_c is high during the last allowed cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc_c = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM master that reads the system-ID slave (ID, then build timestamp)
// and compares both words with build-time values.
// Ports:
//   clock, reset_n          : clock and asynchronous active-low reset
//   start                   : pulse to (re)start a check from IDLE or DONE
//   avm_*                   : Avalon-MM read master (one outstanding read)
//   busy / done / pass      : check status, done and pass sticky until next start
//   id_mismatch/ts_mismatch : compare results; timeout: a read never returned
//   id_value / ts_value     : captured words
module sysid_check_master
  import sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter bit                      CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned             TIMEOUT_CYCLES     = 1024,
  parameter bit                      AUTO_START         = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  input  logic                    avm_waitrequest,
  input  logic                    avm_readdatavalid,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_mismatch,
  output logic                    ts_mismatch,
  output logic                    timeout,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  sysid_state_e state, state_nxt;

  logic                    auto_taken, auto_taken_nxt;
  logic                    addr_nxt, read_nxt, busy_nxt, done_nxt, pass_nxt;
  logic                    id_mm_nxt, ts_mm_nxt, timeout_nxt;
  logic [SYSID_DATA_W-1:0] id_value_nxt, ts_value_nxt;
  logic                    is_req, rd_hit, rd_go, restart;
  logic                    timer_load, timer_en, tc_c;

  sysid_rd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .en      (timer_en),
    .tc_c    (tc_c)
  );

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      auto_taken  <= 1'b0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_nxt;
      auto_taken  <= auto_taken_nxt;
      avm_address <= addr_nxt;
      avm_read    <= read_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pass        <= pass_nxt;
      id_mismatch <= id_mm_nxt;
      ts_mismatch <= ts_mm_nxt;
      timeout     <= timeout_nxt;
      id_value    <= id_value_nxt;
      ts_value    <= ts_value_nxt;
    end
  end

  // Next state, captures and output decode.
  always_comb begin
    state_nxt      = state;
    auto_taken_nxt = auto_taken;
    id_value_nxt   = id_value;
    ts_value_nxt   = ts_value;
    id_mm_nxt      = id_mismatch;
    ts_mm_nxt      = ts_mismatch;
    timeout_nxt    = timeout;
    restart        = 1'b0;

    is_req = (state == ID_REQ) || (state == TS_REQ);
    rd_go  = is_req && !avm_waitrequest;
    // Data counts in a WAIT state, or in the REQ cycle the command is accepted.
    rd_hit = avm_readdatavalid && (!is_req || !avm_waitrequest);

    unique case (state)
      IDLE: restart = start || (AUTO_START && !auto_taken);
      ID_REQ, ID_WAIT: begin
        if (rd_hit) begin
          id_value_nxt = avm_readdata;
          id_mm_nxt    = (avm_readdata != EXPECTED_ID);
          state_nxt    = TS_REQ;
        end else if (tc_c) begin
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (rd_go) begin
          state_nxt = ID_WAIT;
        end
      end
      TS_REQ, TS_WAIT: begin
        if (rd_hit) begin
          ts_value_nxt = avm_readdata;
          ts_mm_nxt    = CHECK_TIMESTAMP && (avm_readdata != EXPECTED_TIMESTAMP);
          state_nxt    = DONE;
        end else if (tc_c) begin
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (rd_go) begin
          state_nxt = TS_WAIT;
        end
      end
      DONE:    restart = start;
      default: state_nxt = IDLE;
    endcase

    if (restart) begin
      state_nxt      = ID_REQ;
      auto_taken_nxt = 1'b1;
      id_value_nxt   = '0;
      ts_value_nxt   = '0;
      id_mm_nxt      = 1'b0;
      ts_mm_nxt      = 1'b0;
      timeout_nxt    = 1'b0;
    end

    // Timer restarts on every entry into a REQ state.
    timer_load = ((state_nxt == ID_REQ) || (state_nxt == TS_REQ)) && (state_nxt != state);
    timer_en   = busy;

    busy_nxt = (state_nxt == ID_REQ) || (state_nxt == ID_WAIT) ||
               (state_nxt == TS_REQ) || (state_nxt == TS_WAIT);
    done_nxt = (state_nxt == DONE);
    read_nxt = (state_nxt == ID_REQ) || (state_nxt == TS_REQ);
    addr_nxt = ((state_nxt == TS_REQ) || (state_nxt == TS_WAIT)) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    // Flags are frozen while in DONE, so this equals the value at DONE entry.
    pass_nxt = done_nxt && !id_mm_nxt && !ts_mm_nxt && !timeout_nxt;
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: randomized Avalon-MM responder plus an
// outcome/latency reference model. Two DUTs run in lockstep on the same bus
// inputs, differing only in CHECK_TIMESTAMP.
module tb_sysid_check_master;
  import sysid_pkg::*;

  localparam logic [31:0] EXP_ID     = SYSID_DEFAULT_ID;
  localparam logic [31:0] EXP_TS     = SYSID_DEFAULT_TIMESTAMP;
  localparam int          TO_CYC     = 16;
  localparam int          DONE_BOUND = 300;

  logic        clock = 1'b0;
  logic        reset_n, start;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;

  logic        a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to;
  logic [31:0] a_id, a_ts;
  logic        b_addr, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
  logic [31:0] b_id, b_ts;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder configuration (written by the main block only).
  int          cfg_wait [2];
  int          cfg_lat  [2];
  bit          cfg_drop [2];
  logic [31:0] cfg_data [2];
  int          clr_seq   = 0;
  int          stray_seq = 0;

  // Responder/monitor state (written by the responder block only).
  int cyc = 0, clr_seen = 0, stray_seen = 0;
  int rise0 = -1, done_cyc = -1, n_acc = 0, stab_err = 0;
  int stall_cnt = 0, lat_cnt = 0;
  bit pending = 1'b0, pend_addr = 1'b0, acc0 = 1'b0, acc1 = 1'b0;
  bit prev_read = 1'b0, prev_done = 1'b0, prev_addr = 1'b0, prev_stall = 1'b0;

  always #5 clock = ~clock;

  sysid_check_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b1),
    .TIMEOUT_CYCLES(TO_CYC), .AUTO_START(1'b1)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(a_addr), .avm_read(a_read), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .busy(a_busy), .done(a_done), .pass(a_pass), .id_mismatch(a_idm),
    .ts_mismatch(a_tsm), .timeout(a_to), .id_value(a_id), .ts_value(a_ts)
  );

  sysid_check_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b0),
    .TIMEOUT_CYCLES(TO_CYC), .AUTO_START(1'b1)
  ) u_dut_nc (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(b_addr), .avm_read(b_read), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .busy(b_busy), .done(b_done), .pass(b_pass), .id_mismatch(b_idm),
    .ts_mismatch(b_tsm), .timeout(b_to), .id_value(b_id), .ts_value(b_ts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model: per-address wait states, read latency, optional dropped response.
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (clr_seen != clr_seq) begin
        clr_seen = clr_seq;
        n_acc = 0; acc0 = 1'b0; acc1 = 1'b0; rise0 = -1; done_cyc = -1;
        stab_err = 0; pending = 1'b0; stall_cnt = 0;
      end
      if (prev_stall && (!a_read || a_addr != prev_addr)) stab_err++;
      if ({a_addr, a_read, a_busy, a_done, a_idm, a_to} !=
          {b_addr, b_read, b_busy, b_done, b_idm, b_to} || a_id != b_id) stab_err++;
      if (a_read && !prev_read && rise0 < 0) rise0 = cyc;
      if (a_done && !prev_done && done_cyc < 0) done_cyc = cyc;
      prev_read = a_read; prev_done = a_done; prev_addr = a_addr;

      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (!reset_n) begin
        pending = 1'b0; stall_cnt = 0;
      end else if (stray_seen != stray_seq) begin
        stray_seen = stray_seq;
        pending    = 1'b0;
        if (!a_read) avm_readdatavalid = 1'b1;
      end else if (pending) begin
        if (lat_cnt > 0) lat_cnt--;
        if (lat_cnt == 0 && !cfg_drop[pend_addr]) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = cfg_data[pend_addr];
          pending           = 1'b0;
        end
      end else if (a_read) begin
        if (stall_cnt < cfg_wait[a_addr]) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          stall_cnt = 0;
          n_acc++;
          if (n_acc == 1) acc0 = a_addr;
          if (n_acc == 2) acc1 = a_addr;
          pend_addr = a_addr;
          lat_cnt   = cfg_lat[a_addr];
          pending   = 1'b1;
          if (lat_cnt == 0 && !cfg_drop[pend_addr]) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = cfg_data[pend_addr];
            pending           = 1'b0;
          end
        end
      end
      prev_stall = a_read && avm_waitrequest;
    end
  end

  // One complete check: launch (start pulse or reset release), wait, compare with model.
  task automatic do_run(input string tag,
                        input int w0, input int l0, input bit d0, input logic [31:0] v0,
                        input int w1, input int l1, input bit d1, input logic [31:0] v1,
                        input bit pulse, input bit mid_start);
    bit          exp_to, exp_idm, exp_tsm;
    logic [31:0] exp_id, exp_tsv;
    int          exp_dur, n;
    cfg_wait[0] = w0; cfg_lat[0] = l0; cfg_drop[0] = d0; cfg_data[0] = v0;
    cfg_wait[1] = w1; cfg_lat[1] = l1; cfg_drop[1] = d1; cfg_data[1] = v1;
    clr_seq++;
    @(negedge clock);
    if (pulse) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check({tag, ":cleared"}, 32'({a_done, a_pass, a_idm, a_tsm, a_to, a_busy}), 32'b000001);
      check({tag, ":cleared_val"}, a_id | a_ts, 32'h0);
    end else begin
      reset_n = 1'b1;
    end
    if (mid_start && a_busy) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    n = 0;
    while (!a_done && n < DONE_BOUND) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);

    exp_to  = d0 || d1;
    exp_id  = d0 ? 32'h0 : v0;
    exp_tsv = exp_to ? 32'h0 : v1;
    exp_idm = !d0 && (v0 != EXP_ID);
    exp_tsm = !exp_to && (v1 != EXP_TS);
    if (d0)      exp_dur = TO_CYC;
    else if (d1) exp_dur = (w0 + 1 + l0) + TO_CYC;
    else         exp_dur = (w0 + 1 + l0) + (w1 + 1 + l1);

    check({tag, ":done"},    32'(a_done), 32'(1));
    check({tag, ":busy"},    32'({a_busy, a_read}), 32'(0));
    check({tag, ":pass"},    32'(a_pass), 32'(!exp_to && !exp_idm && !exp_tsm));
    check({tag, ":id_mm"},   32'(a_idm), 32'(exp_idm));
    check({tag, ":ts_mm"},   32'(a_tsm), 32'(exp_tsm));
    check({tag, ":timeout"}, 32'(a_to), 32'(exp_to));
    check({tag, ":id_val"},  a_id, exp_id);
    check({tag, ":ts_val"},  a_ts, exp_tsv);
    check({tag, ":cycles"},  32'(done_cyc - rise0), 32'(exp_dur));
    check({tag, ":n_acc"},   32'(n_acc), d0 ? 32'(1) : 32'(2));
    check({tag, ":acc_addr"}, 32'({acc0, acc1}), d0 ? 32'b00 : 32'b01);
    check({tag, ":bus_stable"}, 32'(stab_err), 32'(0));
    check({tag, ":nc_pass"}, 32'(b_pass), 32'(!exp_to && !exp_idm));
    check({tag, ":nc_ts_mm"}, 32'(b_tsm), 32'(0));
    check({tag, ":nc_ts_val"}, b_ts, exp_tsv);

    stray_seq++;
    repeat (3) @(negedge clock);
    check({tag, ":stray"}, 32'({a_done, a_busy, a_read}), 32'b100);
    check({tag, ":stray_val"}, a_id ^ a_ts, exp_id ^ exp_tsv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n, w0, l0, w1, l1;
    logic [31:0] v0, v1;
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clock);
    check("reset:ctl", 32'({a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to}), 32'h0);
    check("reset:val", a_id | a_ts, 32'h0);

    // Directed scenarios.
    do_run("auto_basic", 0, 1, 1'b0, EXP_ID, 0, 1, 1'b0, EXP_TS, 1'b0, 1'b0);
    do_run("stall",      3, 4, 1'b0, EXP_ID, 3, 4, 1'b0, EXP_TS, 1'b1, 1'b0);
    do_run("bad_id",     0, 1, 1'b0, 32'h0000_0001, 0, 1, 1'b0, EXP_TS, 1'b1, 1'b0);
    do_run("bad_ts",     0, 1, 1'b0, EXP_ID, 0, 1, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
    do_run("id_timeout", 0, 1, 1'b1, EXP_ID, 0, 1, 1'b0, EXP_TS, 1'b1, 1'b0);
    do_run("ts_timeout", 1, 2, 1'b0, EXP_ID, 0, 1, 1'b1, EXP_TS, 1'b1, 1'b0);
    do_run("zero_lat",   0, 0, 1'b0, EXP_ID, 2, 0, 1'b0, EXP_TS, 1'b1, 1'b0);
    do_run("busy_start", 2, 3, 1'b0, EXP_ID, 1, 2, 1'b0, EXP_TS, 1'b1, 1'b1);

    // Randomized scenarios.
    for (int i = 0; i < 30; i++) begin
      w0 = $urandom_range(0, 4); l0 = $urandom_range(0, 5);
      w1 = $urandom_range(0, 4); l1 = $urandom_range(0, 5);
      v0 = ($urandom_range(0, 1) == 0) ? EXP_ID : 32'($urandom);
      v1 = ($urandom_range(0, 1) == 0) ? EXP_TS : 32'($urandom);
      do_run($sformatf("rnd%0d", i), w0, l0, ($urandom_range(0, 7) == 0), v0,
             w1, l1, ($urandom_range(0, 7) == 0), v1, 1'b1, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of the timestamp read.
    cfg_wait[0] = 1; cfg_lat[0] = 2; cfg_drop[0] = 1'b0; cfg_data[0] = 32'hDEAD_BEEF;
    cfg_wait[1] = 0; cfg_lat[1] = 8; cfg_drop[1] = 1'b0; cfg_data[1] = EXP_TS;
    clr_seq++;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(a_busy && a_addr && !a_read) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("rst:in_ts_wait", 32'({a_busy, a_addr, a_read, a_idm}), 32'b1101);
    #2 reset_n = 1'b0;
    #1;
    check("rst:ctl", 32'({a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to}), 32'h0);
    check("rst:val", a_id | a_ts, 32'h0);
    repeat (2) @(negedge clock);
    do_run("post_reset", 0, 1, 1'b0, EXP_ID, 0, 1, 1'b0, EXP_TS, 1'b0, 1'b0);
    do_run("rerun_bad",  1, 1, 1'b0, 32'h0000_0001, 0, 2, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
    do_run("rerun_good", 0, 3, 1'b0, EXP_ID, 2, 0, 1'b0, EXP_TS, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
